aes_req_scheduler: RTL and testbench

Shares one pipelined AES-128 encryption core among NUM_REQ requesters.
- Arbitrates requester blocks round-robin and issues one block per cycle into the core.
- Tags each block with its requester ID and returns ciphertexts in issue order on one response port.
- The core has no backpressure, so the block enforces credit-based flow control against its response buffer.

---
 rtl/aes_sched_pkg.sv | 14 +
 rtl/aes_sched_fifo.sv | 57 +++++
 rtl/aes_req_scheduler.sv | 164 ++++++++++++++++
 tb/tb_aes_req_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared constants and types for the AES request scheduler.
package aes_sched_pkg;

    localparam int unsigned AES_W         = 128;
    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_RSP_DEPTH = 16;
    localparam int unsigned MAX_ID_W      = 4;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [AES_W-1:0]    cipher;
    } rsp_entry_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module aes_sched_fifo
    import aes_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = DEF_RSP_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin arbiter sharing one pipelined AES-128 core; responses return in
// issue order, tagged with requester ID, under credit-based flow control.
module aes_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH,
    parameter int unsigned CORE_LAT  = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*AES_W-1:0] req_data,
    input  logic [NUM_REQ*AES_W-1:0] req_key,
    output logic                     core_start,
    output logic [AES_W-1:0]         core_data,
    output logic [AES_W-1:0]         core_key,
    input  logic [AES_W-1:0]         core_cipher,
    input  logic                     core_done,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [AES_W-1:0]         rsp_cipher,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic                     err_orphan
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    logic [AES_W-1:0]      w_data_arr [NUM_REQ];
    logic [AES_W-1:0]      w_key_arr  [NUM_REQ];
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       w_idx;
    logic [ID_W-1:0]       w_grant;
    logic                  w_found;
    logic                  w_can_issue;
    logic                  w_handshake;
    logic                  r_core_start;
    logic [AES_W-1:0]      r_core_data;
    logic [AES_W-1:0]      r_core_key;
    logic                  r_err_orphan;
    logic [ID_W-1:0]       w_tag_head;
    logic                  w_tag_empty;
    logic                  w_tag_pop;
    logic [CNT_W-1:0]      w_tag_cnt;
    logic [ID_W+AES_W-1:0] w_rsp_rd;
    logic                  w_rsp_empty;
    logic                  w_rsp_pop;
    logic [CNT_W-1:0]      w_rsp_cnt;
    logic [CRD_W-1:0]      w_credit;
    rsp_entry_t            w_rsp_head;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_data_arr[i] = req_data[AES_W*i +: AES_W];
            w_key_arr[i]  = req_key[AES_W*i +: AES_W];
        end
    end

    // Credit covers both blocks inside the core and entries waiting in the buffer.
    assign w_credit    = CRD_W'(w_tag_cnt) + CRD_W'(w_rsp_cnt);
    assign w_can_issue = !rst && (w_credit < CRD_W'(RSP_DEPTH));

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((32'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_found && w_can_issue) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_handshake = w_found && w_can_issue;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_core_start <= 1'b0;
            r_core_data  <= '0;
            r_core_key   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_core_start <= w_handshake;
            if (w_handshake) begin
                r_ptr       <= ID_W'((32'(w_grant) + 1) % NUM_REQ);
                r_core_data <= w_data_arr[w_grant];
                r_core_key  <= w_key_arr[w_grant];
            end
            if (core_done && w_tag_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign w_tag_pop = core_done && !w_tag_empty;

    aes_sched_fifo #(
        .WIDTH (ID_W),
        .DEPTH (RSP_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_handshake),
        .i_wdata (w_grant),
        .i_pop   (w_tag_pop),
        .o_rdata (w_tag_head),
        .o_empty (w_tag_empty),
        .o_count (w_tag_cnt)
    );

    assign w_rsp_pop = !w_rsp_empty && rsp_ready;

    aes_sched_fifo #(
        .WIDTH (ID_W + AES_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tag_pop),
        .i_wdata ({w_tag_head, core_cipher}),
        .i_pop   (w_rsp_pop),
        .o_rdata (w_rsp_rd),
        .o_empty (w_rsp_empty),
        .o_count (w_rsp_cnt)
    );

    always_comb begin
        w_rsp_head.id     = MAX_ID_W'(w_rsp_rd[AES_W +: ID_W]);
        w_rsp_head.cipher = w_rsp_rd[AES_W-1:0];
    end

    // Head is masked while empty so the uninitialised storage never reaches the port.
    assign rsp_valid  = !w_rsp_empty;
    assign rsp_cipher = rsp_valid ? w_rsp_head.cipher : '0;
    assign rsp_id     = rsp_valid ? w_rsp_head.id[ID_W-1:0] : '0;

    assign core_start = r_core_start;
    assign core_data  = r_core_data;
    assign core_key   = r_core_key;
    assign err_orphan = r_err_orphan;
    assign busy       = (w_credit != '0) || r_core_start;

    a_params: assert property (@(posedge clk)
        (NUM_REQ >= 2) && (NUM_REQ <= 16) && (ID_W == $clog2(NUM_REQ)) && (CORE_LAT >= 1));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        w_credit <= CRD_W'(RSP_DEPTH));
    a_id_extend: assert property (@(posedge clk) disable iff (rst)
        (w_rsp_head.id >> ID_W) == '0);

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler with a behavioural pipelined core model.
module tb_aes_req_scheduler;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned RSP_DEPTH = 16;
    localparam int unsigned CORE_LAT  = 13;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   core_start;
    logic [127:0]           core_data;
    logic [127:0]           core_key;
    logic [127:0]           core_cipher;
    logic                   core_done;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_cipher;
    logic [ID_W-1:0]        rsp_id;
    logic                   busy;
    logic                   err_orphan;

    logic [127:0] pt  [NUM_REQ];
    logic [127:0] key [NUM_REQ];

    int n_tests = 0;
    int n_fail  = 0;

    aes_req_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .RSP_DEPTH (RSP_DEPTH),
        .CORE_LAT  (CORE_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_key     (req_key),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_key    (core_key),
        .core_cipher (core_cipher),
        .core_done   (core_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_cipher  (rsp_cipher),
        .rsp_id      (rsp_id),
        .busy        (busy),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[128*i +: 128] = pt[i];
            req_key[128*i +: 128]  = key[i];
        end
    end

    // Core model: known-answer vector returns the FIPS-197 result, anything else a keyed mix.
    function automatic logic [127:0] cipher_of(input logic [127:0] d, input logic [127:0] k);
        if (d == KAT_PT && k == KAT_KEY) return KAT_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
    endfunction

    logic [CORE_LAT:0] r_pv;
    logic [127:0]      r_pd [CORE_LAT+1];
    logic [127:0]      r_pk [CORE_LAT+1];
    logic              inject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pv <= '0;
        else     r_pv <= {r_pv[CORE_LAT-1:0], core_start};
    end

    always_ff @(posedge clk) begin
        r_pd[0] <= core_data;
        r_pk[0] <= core_key;
        for (int i = 1; i <= CORE_LAT; i++) begin
            r_pd[i] <= r_pd[i-1];
            r_pk[i] <= r_pk[i-1];
        end
    end

    assign core_done   = r_pv[CORE_LAT] | inject;
    assign core_cipher = cipher_of(r_pd[CORE_LAT], r_pk[CORE_LAT]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    function automatic int oh_idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs;
        int got;
        int cyc;
        logic [3:0] e;

        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        inject = 1'b0;
        pt[0]  = 128'h1111_0000_1111_0000_1111_0000_1111_0000;
        pt[1]  = 128'h2222_0101_2222_0101_2222_0101_2222_0101;
        pt[2]  = KAT_PT;
        pt[3]  = 128'h4444_0303_4444_0303_4444_0303_4444_0303;
        key[0] = 128'hdead_beef_0000_0001_dead_beef_0000_0001;
        key[1] = 128'hcafe_f00d_0000_0002_cafe_f00d_0000_0002;
        key[2] = KAT_KEY;
        key[3] = 128'h0bad_c0de_0000_0004_0bad_c0de_0000_0004;

        // Pointer starts at 0; each row is one cycle, pointer carried between rows.
        tbl[0]  = '{valid: 4'b1111, exp_ready: 4'b0001};
        tbl[1]  = '{valid: 4'b1111, exp_ready: 4'b0010};
        tbl[2]  = '{valid: 4'b1111, exp_ready: 4'b0100};
        tbl[3]  = '{valid: 4'b1111, exp_ready: 4'b1000};
        tbl[4]  = '{valid: 4'b0000, exp_ready: 4'b0000};
        tbl[5]  = '{valid: 4'b1000, exp_ready: 4'b1000};
        tbl[6]  = '{valid: 4'b0010, exp_ready: 4'b0010};
        tbl[7]  = '{valid: 4'b0001, exp_ready: 4'b0001};
        tbl[8]  = '{valid: 4'b0101, exp_ready: 4'b0100};
        tbl[9]  = '{valid: 4'b0011, exp_ready: 4'b0001};
        tbl[10] = '{valid: 4'b1001, exp_ready: 4'b1000};
        tbl[11] = '{valid: 4'b0110, exp_ready: 4'b0010};

        // Reset state
        do_reset();
        check("rst req_ready", 128'(req_ready), 128'h0);
        check("rst core_start", 128'(core_start), 128'h0);
        check("rst core_data", core_data, 128'h0);
        check("rst core_key", core_key, 128'h0);
        check("rst rsp_valid", 128'(rsp_valid), 128'h0);
        check("rst busy", 128'(busy), 128'h0);
        check("rst err_orphan", 128'(err_orphan), 128'h0);

        // Known-answer block from requester 2
        req_valid = 4'b0100;
        #1 check("kat ready", 128'(req_ready), 128'(4'b0100));
        tick();
        req_valid = '0;
        check("kat core_start", 128'(core_start), 128'h1);
        check("kat core_key", core_key, KAT_KEY);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("kat latency", 128'(n), 128'd15);
        check("kat cipher", rsp_cipher, KAT_CT);
        check("kat id", 128'(rsp_id), 128'd2);
        check("kat busy", 128'(busy), 128'h1);

        // Table-driven arbitration
        do_reset();
        rsp_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            req_valid = tbl[r].valid;
            #1 check($sformatf("tbl%0d ready", r), 128'(req_ready), 128'(tbl[r].exp_ready));
            tick();
            check($sformatf("tbl%0d start", r), 128'(core_start), 128'(|tbl[r].exp_ready));
            if (|tbl[r].exp_ready) begin
                check($sformatf("tbl%0d data", r), core_data, pt[oh_idx(tbl[r].exp_ready)]);
                check($sformatf("tbl%0d key", r), core_key, key[oh_idx(tbl[r].exp_ready)]);
            end
        end
        req_valid = '0;

        // All requesters continuously valid for 8 cycles
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            e = 4'(1 << (k % 4));
            #1 check($sformatf("rr%0d ready", k), 128'(req_ready), 128'(e));
            tick();
            check($sformatf("rr%0d start", k), 128'(core_start), 128'h1);
        end
        req_valid = '0;
        tick();
        check("rr start low", 128'(core_start), 128'h0);
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 60) begin
            if (rsp_valid) begin
                check($sformatf("rr rsp%0d id", got), 128'(rsp_id), 128'(got % 4));
                check($sformatf("rr rsp%0d cipher", got), rsp_cipher,
                      cipher_of(pt[got % 4], key[got % 4]));
                got++;
            end
            tick();
            cyc++;
        end
        check("rr rsp count", 128'(got), 128'd8);

        // Wrap through index 0: requester 3 then requester 1
        do_reset();
        req_valid = 4'b1000;
        #1 check("wrap ready3", 128'(req_ready), 128'(4'b1000));
        tick();
        check("wrap data3", core_data, pt[3]);
        req_valid = 4'b0010;
        #1 check("wrap ready1", 128'(req_ready), 128'(4'b0010));
        tick();
        req_valid = '0;
        check("wrap data1", core_data, pt[1]);
        check("wrap start", 128'(core_start), 128'h1);

        // Credit exhaustion with a stalled consumer
        do_reset();
        req_valid = 4'b0001;
        hs = 0;
        for (int c = 0; c < 60; c++) begin
            #1 if (req_ready == 4'b0001) hs++;
            tick();
        end
        check("full handshakes", 128'(hs), 128'd16);
        check("full ready", 128'(req_ready), 128'h0);
        check("full rsp_valid", 128'(rsp_valid), 128'h1);
        rsp_ready = 1'b1;
        #1 check("pop cycle ready", 128'(req_ready), 128'h0);
        check("pop id", 128'(rsp_id), 128'd0);
        tick();
        rsp_ready = 1'b0;
        #1 check("after pop ready", 128'(req_ready), 128'(4'b0001));
        tick();
        check("after pop start", 128'(core_start), 128'h1);
        check("refull ready", 128'(req_ready), 128'h0);
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            #1 if (req_ready != 4'b0000) hs++;
            tick();
        end
        check("refull handshakes", 128'(hs), 128'd0);
        req_valid = '0;

        // Asynchronous reset with 3 buffered and 5 in flight
        do_reset();
        req_valid = 4'b0001;
        repeat (3) tick();
        req_valid = '0;
        repeat (20) tick();
        req_valid = 4'b0001;
        repeat (5) tick();
        req_valid = '0;
        repeat (3) tick();
        check("mid busy", 128'(busy), 128'h1);
        check("mid rsp_valid", 128'(rsp_valid), 128'h1);
        #2 rst = 1'b1;
        #1;
        check("async req_ready", 128'(req_ready), 128'h0);
        check("async core_start", 128'(core_start), 128'h0);
        check("async core_data", core_data, 128'h0);
        check("async core_key", core_key, 128'h0);
        check("async rsp_valid", 128'(rsp_valid), 128'h0);
        check("async rsp_cipher", rsp_cipher, 128'h0);
        check("async rsp_id", 128'(rsp_id), 128'h0);
        check("async busy", 128'(busy), 128'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();
        check("post rst rsp_valid", 128'(rsp_valid), 128'h0);
        check("post rst busy", 128'(busy), 128'h0);
        req_valid = 4'b1111;
        #1 check("post rst grant", 128'(req_ready), 128'(4'b0001));
        req_valid = '0;

        // Orphan core_done
        do_reset();
        repeat (2) tick();
        check("orphan before", 128'(err_orphan), 128'h0);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check("orphan set", 128'(err_orphan), 128'h1);
        check("orphan rsp_valid", 128'(rsp_valid), 128'h0);
        repeat (5) tick();
        check("orphan sticky", 128'(err_orphan), 128'h1);
        check("orphan rsp_valid late", 128'(rsp_valid), 128'h0);
        check("orphan busy", 128'(busy), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
